// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory bridge.
package dmem_pkg;
  localparam int DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;
endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous word array with per-byte write enables.
// The read port is registered; the output register (not the storage) is
// cleared by reset and can be forced to zero on a read.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           read_en,
  input  logic                           read_clear,
  input  logic [DMEM_WORD_BYTES-1:0]     write_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [31:0]                    write_word,
  output logic [31:0]                    read_word
);
  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes; the storage itself is never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DMEM_WORD_BYTES; b++)
      if (write_be[b]) mem[index][8*b +: 8] <= write_word[8*b +: 8];
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst)          read_word <= '0;
    else if (read_en) read_word <= read_clear ? '0 : mem[index];
  end
endmodule

// File: rtl/data_mem_bridge.sv
// Core-side data memory bridge: request/ready handshake with a fixed number
// of wait states in front of a synchronous byte-writable word array.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag out-of-range
// addresses with err (read returns zero, write suppressed) instead of
// wrapping them modulo the array depth.
module data_mem_bridge
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_rdy,
  input  logic        write_enable,
  input  logic [3:0]  write_byte_enable,
  input  logic [31:0] write_data,
  output logic        write_rdy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_t state, state_nx;
  logic [3:0]  cnt;

  // request captured at acceptance
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        rd_q, wr_q, oob_q;

  logic          req, hold, oob_in, cur_wr, cur_oob;
  logic [31:0]   cur_addr;
  logic [AW-1:0] index;
  logic          sram_rd;
  logic [3:0]    sram_be;

  assign req  = read_enable | write_enable;
  // a combined read+write is a write, so the write enable is what must stay up
  assign hold = wr_q ? write_enable : read_enable;

`ifdef DMEM_BOUNDS_CHECK_EN
  // offset arithmetic wraps, so addresses below the base also land out of range
  assign oob_in = (address - BASE_ADDR) >= 32'(DEPTH_WORDS * DMEM_WORD_BYTES);
`else
  assign oob_in = 1'b0;
`endif

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == WAIT && state_nx == WAIT) ? cnt + 4'd1 : 4'd0;
    end
  end

  // Latch the request when it is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_q  <= address;
      wdata_q <= write_data;
      be_q    <= write_byte_enable;
      rd_q    <= read_enable;
      wr_q    <= write_enable;
      oob_q   <= oob_in;
    end
  end

  // Next-state: accept, count wait states (abort if enable drops), respond.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!hold)                 state_nx = IDLE;
        else if (cnt == WAIT_LAST) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs; reset looks like IDLE to the core.
  always_comb begin
    read_rdy  = 1'b0;
    write_rdy = 1'b0;
    err       = 1'b0;
    if (rst || state == IDLE) begin
      read_rdy  = !read_enable;
      write_rdy = !write_enable;
    end else if (state == RESP) begin
      read_rdy  = rd_q;
      write_rdy = wr_q;
      err       = oob_q;
    end
  end

  // Array control: read on the edge entering RESP, write on the edge leaving it.
  // In IDLE the live inputs are used so zero-wait-state reads still hit RESP.
  always_comb begin
    cur_addr = (state == IDLE) ? address      : addr_q;
    cur_wr   = (state == IDLE) ? write_enable : wr_q;
    cur_oob  = (state == IDLE) ? oob_in       : oob_q;
    index    = AW'((cur_addr - BASE_ADDR) >> 2);
    sram_rd  = !rst && state_nx == RESP && !cur_wr;
    sram_be  = (!rst && state == RESP && wr_q && !oob_q) ? be_q : 4'b0000;
  end

  dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .read_en    (sram_rd),
    .read_clear (cur_oob),
    .write_be   (sram_be),
    .index      (index),
    .write_word (wdata_q),
    .read_word  (read_data)
  );
endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed cases plus randomized traffic checked
// against a word-array model. A second instance runs with zero wait states.
module tb_data_mem_bridge;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic        read_enable = 1'b0, write_enable = 1'b0, read_rdy, write_rdy, err;
  logic [3:0]  write_byte_enable = '0;

  logic [31:0] address0 = '0, write_data0 = '0, read_data0;
  logic        read_enable0 = 1'b0, write_enable0 = 1'b0, read_rdy0, write_rdy0, err0;
  logic [3:0]  write_byte_enable0 = '0;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] last_rd;
  bit          last_known;

  always #5 clk = ~clk;

  data_mem_bridge #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst), .address(address), .read_enable(read_enable),
    .read_data(read_data), .read_rdy(read_rdy), .write_enable(write_enable),
    .write_byte_enable(write_byte_enable), .write_data(write_data),
    .write_rdy(write_rdy), .err(err)
  );

  data_mem_bridge #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .address(address0), .read_enable(read_enable0),
    .read_data(read_data0), .read_rdy(read_rdy0), .write_enable(write_enable0),
    .write_byte_enable(write_byte_enable0), .write_data(write_data0),
    .write_rdy(write_rdy0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // One complete transaction on the main instance, checked against the model.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input string tag);
    logic [31:0] off;
    logic        oob;
    int          idx, lat;
    off = a;
    oob = BOUNDS && (off >= 32'(DEPTH * 4));
    idx = int'((off >> 2) % DEPTH);
    @(negedge clk);
    address = a; read_enable = rd; write_enable = wr;
    write_data = d; write_byte_enable = be;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(wr ? write_rdy : read_rdy) && lat < 20);
    check({tag, ".latency"}, lat, WS + 1);
    if (rd && wr) check({tag, ".both_rdy"}, read_rdy, 1'b1);
    check({tag, ".err"}, err, oob);
    if (rd && !wr) begin
      last_known = oob || known[idx];
      last_rd    = oob ? 32'h0 : mem[idx];
    end
    if (last_known) check({tag, ".data"}, read_data, last_rd);
    read_enable = 1'b0; write_enable = 1'b0;
    @(posedge clk); #1;
    if (wr && !oob) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] = d[8*b +: 8];
      if (be == 4'hF) known[idx] = 1'b1;
    end
    check({tag, ".idle_rdy"}, {read_rdy, write_rdy}, 2'b11);
  endtask

  // Request dropped in the first wait cycle: must abort silently.
  task automatic abort_req(input logic wr, input logic [31:0] a, input string tag);
    @(negedge clk);
    address = a; read_enable = !wr; write_enable = wr;
    write_data = 32'hBAD0_BAD0; write_byte_enable = 4'hF;
    @(posedge clk); #1;
    check({tag, ".wait_rdy"}, wr ? write_rdy : read_rdy, 1'b0);
    read_enable = 1'b0; write_enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check({tag, ".no_pulse"}, {read_rdy, write_rdy, err}, 3'b110);
    end
    if (last_known) check({tag, ".data_hold"}, read_data, last_rd);
  endtask

  initial begin
    logic [31:0] a;
    int          w, op;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.read_data", read_data, 32'h0);
    check("rst.err", err, 1'b0);
    check("rst.rdy", {read_rdy, write_rdy}, 2'b11);
    check("rst.read_data0", read_data0, 32'h0);
    rst = 1'b0;
    last_rd = 32'h0; last_known = 1'b1;

    // full write then read-back of the same word
    do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr_deadbeef");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_deadbeef");

    // partial lane write, then an all-lanes-off write that must change nothing
    do_req(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, "wr_base");
    do_req(1'b0, 1'b1, 32'h20, 32'h0000_00AA, 4'b0001, "wr_lane0");
    do_req(1'b0, 1'b1, 32'h22, 32'hFFFF_FFFF, 4'b0000, "wr_be0");
    do_req(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, "rd_partial");
    check("partial.model", mem[8], 32'h1122_33AA);

    // combined read+write: write only, read_data untouched
    do_req(1'b1, 1'b1, 32'h40, 32'h55AA_55AA, 4'hF, "both");
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "rd_both");

    // aborts leave the array and read_data alone
    abort_req(1'b0, 32'h20, "abort_rd");
    abort_req(1'b1, 32'h10, "abort_wr");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd_after_abort");

    // reset during the wait of a write
    do_req(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, "wr_pre_rst");
    @(negedge clk);
    address = 32'h30; write_enable = 1'b1; write_data = 32'h0BAD_F00D; write_byte_enable = 4'hF;
    @(posedge clk); #1;
    check("rst_mid.wait_rdy", write_rdy, 1'b0);
    rst = 1'b1; write_enable = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.read_data", read_data, 32'h0);
    check("rst_mid.rdy", {read_rdy, write_rdy, err}, 3'b110);
    rst = 1'b0;
    last_rd = 32'h0; last_known = 1'b1;
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "rd_post_rst");

    // out-of-range write: flagged with bounds checking, wraps to word 0 otherwise
    do_req(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, "wr_word0");
    do_req(1'b0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, "wr_oob");
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "rd_word0");
    do_req(1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, "rd_oob");

    // randomized traffic over a small window, with occasional high addresses
    for (int n = 0; n < 60; n++) begin
      w  = $urandom_range(0, 15);
      a  = 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      op = $urandom_range(0, 9);
      if (op < 4)       do_req(1'b0, 1'b1, a, $urandom, 4'hF, "rnd_wr");
      else if (op < 8)  do_req(1'b1, 1'b0, a, 32'h0, 4'h0, "rnd_rd");
      else if (op == 8) do_req(1'b1, 1'b1, a, $urandom, 4'hF, "rnd_both");
      else              do_req(1'b0, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), "rnd_be");
    end

    // zero wait states: held enables give a response every other cycle
    @(negedge clk);
    address0 = 32'h0; write_enable0 = 1'b1; write_data0 = 32'h0000_1111; write_byte_enable0 = 4'hF;
    @(posedge clk); #1;
    check("ws0.wr0_rdy", write_rdy0, 1'b1);
    address0 = 32'h4; write_data0 = 32'h0000_2222;
    @(posedge clk); #1;
    check("ws0.wr_gap", write_rdy0, 1'b0);
    @(posedge clk); #1;
    check("ws0.wr1_rdy", write_rdy0, 1'b1);
    write_enable0 = 1'b0;
    @(posedge clk); #1;
    address0 = 32'h0; read_enable0 = 1'b1;
    @(posedge clk); #1;
    check("ws0.rd0_rdy", read_rdy0, 1'b1);
    check("ws0.rd0_data", read_data0, 32'h0000_1111);
    address0 = 32'h4;
    @(posedge clk); #1;
    check("ws0.rd_gap", read_rdy0, 1'b0);
    @(posedge clk); #1;
    check("ws0.rd1_rdy", read_rdy0, 1'b1);
    check("ws0.rd1_data", read_data0, 32'h0000_2222);
    check("ws0.err", err0, 1'b0);
    read_enable0 = 1'b0;
    @(posedge clk); #1;
    check("ws0.idle_rdy", {read_rdy0, write_rdy0}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 The block SHALL provide parameter DEPTH_WORDS, default 1024, as the number of 32-bit words in the backing array (power of two).
REQ-002 The block SHALL provide parameter WAIT_STATES, default 2, as the number of stall cycles inserted before each response (0..15).
REQ-003 The block SHALL provide parameter BASE_ADDR, default 32'h0000_0000, as the byte address of array word 0.
REQ-004 The block SHALL use clk (input, 1 bit) as its clock, with reset rst (input, 1 bit), synchronous, active-high.
REQ-005 The block SHALL provide address, input, 32 bits: the byte address from the core.
REQ-006 The block SHALL provide read_enable, input, 1 bit: a read request, held by the core until read_rdy.
REQ-007 The block SHALL provide read_data, output, 32 bits: the read word, valid in the response cycle.
REQ-008 The block SHALL provide read_rdy, output, 1 bit: the read ready/acknowledge.
REQ-009 The block SHALL provide write_enable, input, 1 bit: a write request, held until write_rdy.
REQ-010 The block SHALL provide write_byte_enable, input, 4 bits: lane mask, where bit n enables bits [8n+7:8n].
REQ-011 The block SHALL provide write_data, input, 32 bits: the write word.
REQ-012 The block SHALL provide write_rdy, output, 1 bit: the write ready/acknowledge.
REQ-013 The block SHALL provide err, output, 1 bit: an out-of-range pulse, valid in the response cycle.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; IDLE->WAIT when a request is accepted and WAIT_STATES>0; IDLE->RESP when a request is accepted and WAIT_STATES==0; WAIT->RESP when the wait counter reaches WAIT_STATES-1; RESP->IDLE unconditionally.
REQ-015 A request SHALL be accepted in IDLE on any cycle with read_enable or write_enable high; the block latches address, write_data, write_byte_enable and the operation type at acceptance.
REQ-016 If read_enable and write_enable are both high at acceptance, the block SHALL perform the write only, and assert both read_rdy and write_rdy in RESP.
REQ-017 Response latency SHALL be exactly WAIT_STATES+1 cycles: accepted at edge T, RESP during the cycle after edge T+WAIT_STATES.
REQ-018 read_rdy SHALL be high in IDLE while read_enable is low, low from acceptance through WAIT, and high in RESP for a read; write_rdy SHALL follow the same rule for writes.
REQ-019 read_data SHALL be driven from a register, equal to the addressed word in RESP, and held until the next read's RESP.
REQ-020 The word index SHALL be (address-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits; address[1:0] SHALL be ignored for indexing.
REQ-021 A write SHALL commit at the clock edge ending RESP, updating only the enabled lanes; write_byte_enable==4'b0000 SHALL complete the handshake with no array change.
REQ-022 A read in RESP of a word written by the immediately preceding request SHALL return the new data.
REQ-023 If the requesting enable drops during WAIT, the block SHALL abort: return to IDLE next cycle, perform no write, and assert no rdy for that request.
REQ-024 Enable still high in the IDLE cycle after RESP SHALL be treated as a new request.

Reset
REQ-025 While rst is high, the block SHALL force state IDLE, wait counter 0, read_data 32'h0 and err 0, with read_rdy and write_rdy evaluated per REQ-018 (high when the enables are low).
REQ-026 Reset mid-operation SHALL abort the transaction with no array write.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 With DMEM_BOUNDS_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL pulse err in RESP, return read_data 32'h0 and suppress the write, with rdy still asserted.
REQ-029 Without DMEM_BOUNDS_CHECK_EN, err SHALL be tied 0 and out-of-range addresses SHALL wrap modulo the depth per REQ-020.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum dmem_state_t {IDLE, WAIT, RESP} and the constant DMEM_WORD_BYTES=4.
REQ-031 The storage SHALL be the single sub-module dmem_sram_array: single-port, synchronous, with per-byte write enable.

Verification
REQ-032 With WAIT_STATES=2, a write of 32'hDEADBEEF with be=4'hF to address 32'h10, then a read of 32'h10, SHALL give each rdy exactly 3 cycles after acceptance and read_data=32'hDEADBEEF.
REQ-033 A partial write of 32'h000000AA with be=4'b0001 over the word 32'h11223344 SHALL read back 32'h112233AA.
REQ-034 Dropping read_enable in the first WAIT cycle SHALL return the FSM to IDLE, produce no read_rdy pulse and leave the array unchanged.
REQ-035 With WAIT_STATES=0, back-to-back reads of addresses 0 and 4 SHALL each complete in 1 cycle, with read_rdy pulsing in alternate cycles.
REQ-036 With DMEM_BOUNDS_CHECK_EN and DEPTH_WORDS=1024, a write to 32'h1000 SHALL pulse err with no write performed; without the macro, the same write SHALL land in word 0.
REQ-037 Asserting rst during WAIT of a write SHALL leave the array unchanged, put the FSM in IDLE and set read_data to 32'h0.
